mem_exc_unit: RTL

MEM-stage exception unit for the pipelined core; the parametrised successor of the combinational MEM vector check. It classifies each data access (misalignment, user-mode protection, new write-protect window) and merges the result with the vector arriving from EX. It registers the merged vector into the MEM/WB boundary and captures the first faulting access into cause/bad-address registers. That capture is presented to the control unit as a held trap request with an acknowledge handshake.

---
 rtl/mem_exc_pkg.sv | 30 +++
 rtl/mem_exc_if.sv | 49 ++++
 rtl/mem_exc_classify.sv | 75 +++++++
 rtl/mem_exc_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_exc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_exc_pkg                                                  |
// | Description : Shared definitions for the MEM-stage exception unit:         |
// |               default vector codes, access-size encodings and the trap     |
// |               state encoding.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_exc_pkg;

  // Default exception vector codes
  localparam logic [4:0] c_vec_misalign = 5'b01011;
  localparam logic [4:0] c_vec_memfault = 5'b01001;

  // Access size encodings
  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  // Trap request FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } trap_state_e;

endpackage : mem_exc_pkg
`default_nettype wire

// File: rtl/mem_exc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_exc_if                                                   |
// | Description : Bundle between the MEM pipeline/control unit and the         |
// |               exception unit.                                              |
// |   Pipeline -> unit : data_address, vector_ex, size, s_u, memwrite,         |
// |                      memread, stall, flush, trap_ack                       |
// |   Unit -> pipeline : mem_kill, vector_mem, trap_req, trap_cause,           |
// |                      trap_badaddr, drop_cnt                                |
// |   Modports: master = pipeline/control side, slave = exception unit.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mem_exc_if #(
  parameter int ADDR_W = 32,
  parameter int VEC_W  = 5,
  parameter int CNT_W  = 8
);
  import mem_exc_pkg::*;

  logic [ADDR_W-1:0] data_address;
  logic [VEC_W-1:0]  vector_ex;
  logic [1:0]        size;
  logic              s_u;
  logic              memwrite;
  logic              memread;
  logic              stall;
  logic              flush;
  logic              mem_kill;
  logic [VEC_W-1:0]  vector_mem;
  logic              trap_req;
  logic              trap_ack;
  logic [VEC_W-1:0]  trap_cause;
  logic [ADDR_W-1:0] trap_badaddr;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output data_address, vector_ex, size, s_u, memwrite, memread,
           stall, flush, trap_ack,
    input  mem_kill, vector_mem, trap_req, trap_cause, trap_badaddr, drop_cnt
  );

  modport slave (
    input  data_address, vector_ex, size, s_u, memwrite, memread,
           stall, flush, trap_ack,
    output mem_kill, vector_mem, trap_req, trap_cause, trap_badaddr, drop_cnt
  );

endinterface : mem_exc_if
`default_nettype wire

// File: rtl/mem_exc_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_exc_classify                                             |
// | Description : Combinational classification of one data access              |
// |               (misalignment, user protection, write-protect window) and    |
// |               merge with the vector arriving from EX.                      |
// |   Inputs : data_address, vector_ex, size, s_u, memwrite, memread           |
// |   Outputs: next_vec (merged vector), mem_kill (suppress the access)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_exc_classify
  import mem_exc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                VEC_W        = 5,
  parameter logic [VEC_W-1:0]  VEC_MISALIGN = c_vec_misalign,
  parameter logic [VEC_W-1:0]  VEC_MEMFAULT = c_vec_memfault,
  parameter logic [ADDR_W-1:0] PROT_LIMIT   = 32'h0001_0000,
  parameter bit                WP_EN        = 1'b1,
  parameter logic [ADDR_W-1:0] WP_BASE      = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] WP_LIMIT     = 32'h0002_0000
) (
  input  logic [ADDR_W-1:0] data_address,
  input  logic [VEC_W-1:0]  vector_ex,
  input  logic [1:0]        size,
  input  logic              s_u,
  input  logic              memwrite,
  input  logic              memread,
  output logic [VEC_W-1:0]  next_vec,
  output logic              mem_kill
);

  logic w_active;
  logic w_misalign;
  logic w_below_limit;
  logic w_in_wp_window;
  logic w_protect;

  assign w_active = memwrite | memread;

  always_comb begin
    w_misalign = 1'b0;
    if (w_active) begin
      case (size_e'(size))
        SIZE_WORD: w_misalign = (data_address[1:0] != 2'b00);
        SIZE_HALF: w_misalign = data_address[0];
        SIZE_BYTE: w_misalign = 1'b0;
        SIZE_RSVD: w_misalign = 1'b1;
        default:   w_misalign = 1'b1;
      endcase
    end
  end

  assign w_below_limit  = (data_address < PROT_LIMIT);
  assign w_in_wp_window = WP_EN && memwrite &&
                          (data_address >= WP_BASE) && (data_address < WP_LIMIT);
  assign w_protect      = w_active && s_u && (w_below_limit || w_in_wp_window);

  // Higher EX codes outrank everything; lower nonzero EX codes are only
  // displaced by a MEM-stage fault.
  always_comb begin
    next_vec = vector_ex;
    if (vector_ex > VEC_MISALIGN) begin
      next_vec = vector_ex;
    end else if (w_misalign) begin
      next_vec = VEC_MISALIGN;
    end else if (w_protect) begin
      next_vec = VEC_MEMFAULT;
    end
  end

  assign mem_kill = (next_vec != vector_ex) || (vector_ex != '0);

endmodule : mem_exc_classify
`default_nettype wire

// File: rtl/mem_exc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_exc_unit                                                 |
// | Description : MEM-stage exception unit. Registers the merged exception     |
// |               vector into MEM/WB, captures the first faulting access into  |
// |               cause/bad-address registers and holds a trap request for     |
// |               the control unit until acknowledged.                         |
// |   clk   : clock                                                            |
// |   rst_n : asynchronous active-low reset                                    |
// |   bus   : mem_exc_if.slave (access inputs, kill, MEM/WB vector, trap       |
// |           request/acknowledge, captured cause/address, drop counter)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_exc_unit
  import mem_exc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                VEC_W        = 5,
  parameter logic [VEC_W-1:0]  VEC_MISALIGN = c_vec_misalign,
  parameter logic [VEC_W-1:0]  VEC_MEMFAULT = c_vec_memfault,
  parameter logic [ADDR_W-1:0] PROT_LIMIT   = 32'h0001_0000,
  parameter bit                WP_EN        = 1'b1,
  parameter logic [ADDR_W-1:0] WP_BASE      = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] WP_LIMIT     = 32'h0002_0000,
  parameter int                CNT_W        = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_exc_if.slave  bus
);

  logic [VEC_W-1:0]  w_next_vec;
  logic              w_mem_kill;
  logic              w_load;
  logic              w_fault_load;

  trap_state_e       r_state;
  trap_state_e       w_state_nxt;
  logic              w_capture;
  logic              w_drop;

  logic [VEC_W-1:0]  r_vector_mem;
  logic [VEC_W-1:0]  r_trap_cause;
  logic [ADDR_W-1:0] r_trap_badaddr;
  logic [CNT_W-1:0]  r_drop_cnt;

  mem_exc_classify #(
    .ADDR_W       (ADDR_W),
    .VEC_W        (VEC_W),
    .VEC_MISALIGN (VEC_MISALIGN),
    .VEC_MEMFAULT (VEC_MEMFAULT),
    .PROT_LIMIT   (PROT_LIMIT),
    .WP_EN        (WP_EN),
    .WP_BASE      (WP_BASE),
    .WP_LIMIT     (WP_LIMIT)
  ) u_classify (
    .data_address (bus.data_address),
    .vector_ex    (bus.vector_ex),
    .size         (bus.size),
    .s_u          (bus.s_u),
    .memwrite     (bus.memwrite),
    .memread      (bus.memread),
    .next_vec     (w_next_vec),
    .mem_kill     (w_mem_kill)
  );

  // Only an actual load into MEM/WB can raise or drop a trap; stalled or
  // flushed faults never reach the trap logic.
  assign w_load       = !bus.flush && !bus.stall;
  assign w_fault_load = w_load && (w_next_vec != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vector_mem <= '0;
    end else if (bus.flush) begin
      r_vector_mem <= '0;
    end else if (!bus.stall) begin
      r_vector_mem <= w_next_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fault_load) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bus.trap_ack) begin
          // Acknowledge in the same cycle as a new fault hands the next
          // trap over without a gap.
          if (w_fault_load) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_fault_load) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_cause   <= '0;
      r_trap_badaddr <= '0;
    end else if (w_capture) begin
      r_trap_cause   <= w_next_vec;
      r_trap_badaddr <= bus.data_address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bus.mem_kill     = w_mem_kill;
  assign bus.vector_mem   = r_vector_mem;
  assign bus.trap_req     = (r_state == ST_PEND);
  assign bus.trap_cause   = r_trap_cause;
  assign bus.trap_badaddr = r_trap_badaddr;
  assign bus.drop_cnt     = r_drop_cnt;

endmodule : mem_exc_unit
`default_nettype wire
